// File: rtl/imem_port_arbiter.sv
// Shares one 1-cycle-latency memory port between instruction fetch and load/store.
// Optional starvation guard for fetch is enabled by defining IMEM_ARB_STARVE_GUARD_EN.
module imem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [31:0]       if_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [3:0]        d_be_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [31:0]       d_wdata_i,
   output logic              d_gnt_o,
   output logic              d_rvalid_o,
   output logic [31:0]       d_rdata_o,
   output logic              m_req_o,
   output logic              m_we_o,
   output logic [3:0]        m_be_o,
   output logic [ADDR_W-1:0] m_addr_o,
   output logic [31:0]       m_wdata_o,
   input  logic [31:0]       m_rdata_i
);

   typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D} state_t;

   state_t state_q, state_d;
   logic   d_we_q, d_we_d;
   logic   force_if;

   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
      $error("STARVE_MAX must be in 1..15");
   end

`ifdef IMEM_ARB_STARVE_GUARD_EN
   logic [3:0] starve_q, starve_d;

   assign force_if = if_req_i && (starve_q == 4'(STARVE_MAX));

   // Counts consecutive denied fetch cycles, saturating at the threshold.
   always_comb begin
      starve_d = '0;
      if (if_req_i && !if_gnt_o)
         starve_d = (starve_q == 4'(STARVE_MAX)) ? starve_q : starve_q + 4'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) starve_q <= '0;
      else     starve_q <= starve_d;
   end
`else
   assign force_if = 1'b0;
`endif

   assign if_gnt_o = !rst && if_req_i && (!d_req_i || force_if);
   assign d_gnt_o  = !rst && d_req_i && !force_if;

   always_comb begin
      m_req_o   = 1'b0;
      m_we_o    = 1'b0;
      m_be_o    = '0;
      m_addr_o  = '0;
      m_wdata_o = '0;
      if (d_gnt_o) begin
         m_req_o   = 1'b1;
         m_we_o    = d_we_i;
         m_be_o    = d_be_i;
         m_addr_o  = d_addr_i;
         m_wdata_o = d_wdata_i;
      end else if (if_gnt_o) begin
         m_req_o   = 1'b1;
         m_be_o    = 4'hF;
         m_addr_o  = if_addr_i;
      end
   end

   // Response owner for the access issued this cycle.
   always_comb begin
      state_d = IDLE;
      d_we_d  = 1'b0;
      if (if_gnt_o) begin
         state_d = RESP_IF;
      end else if (d_gnt_o) begin
         state_d = RESP_D;
         d_we_d  = d_we_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         d_we_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         d_we_q  <= d_we_d;
      end
   end

   assign if_rvalid_o = (state_q == RESP_IF);
   assign d_rvalid_o  = (state_q == RESP_D);
   assign if_rdata_o  = if_rvalid_o ? m_rdata_i : 32'h0;
   assign d_rdata_o   = (d_rvalid_o && !d_we_q) ? m_rdata_i : 32'h0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: byte memory environment plus transaction-level reference model.
module tb_imem_port_arbiter;
   localparam int AW = 32;
   localparam int SM = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, d_req, d_we;
   logic [AW-1:0] if_addr, d_addr;
   logic [3:0]    d_be;
   logic [31:0]   d_wdata;
   logic          if_gnt, if_rvalid, d_gnt, d_rvalid;
   logic [31:0]   if_rdata, d_rdata;
   logic          m_req, m_we;
   logic [3:0]    m_be;
   logic [AW-1:0] m_addr;
   logic [31:0]   m_wdata;
   logic [31:0]   m_rdata = 32'h0;

   imem_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
      .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
      .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
      .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
      .m_req_o(m_req), .m_we_o(m_we), .m_be_o(m_be), .m_addr_o(m_addr),
      .m_wdata_o(m_wdata), .m_rdata_i(m_rdata)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:255];

   function automatic logic [31:0] rd(input logic [31:0] addr);
      int a;
      a = int'(addr[7:0]) & 'hFC;
      return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
   endfunction

   // Memory environment: read data registered one cycle after the strobe.
   always @(posedge clk) begin
      if (m_req) begin
         m_rdata <= rd(m_addr);
         if (m_we)
            for (int b = 0; b < 4; b++)
               if (m_be[b]) mem[(int'(m_addr[7:0]) & 'hFC) + b] <= m_wdata[8*b +: 8];
      end
   end

   int errors = 0;
   int checks = 0;
   int pend_kind = 0;          // 0 none, 1 fetch, 2 data
   logic [31:0] pend_data = 32'h0;
   int streak = 0;
   logic last_ig = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [3:0] db, input logic [31:0] da, input logic [31:0] dwd);
      logic eig, edg, frc;
      @(negedge clk);
      if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_be = db; d_addr = da; d_wdata = dwd;
      #1;
      frc = 1'b0;
`ifdef IMEM_ARB_STARVE_GUARD_EN
      frc = ir && (streak == SM);
`endif
      eig = ir && (!dr || frc);
      edg = dr && !frc;
      chk("if_gnt",    32'(if_gnt), 32'(eig));
      chk("d_gnt",     32'(d_gnt),  32'(edg));
      chk("gnt_excl",  32'(if_gnt & d_gnt), 32'h0);
      chk("m_req",     32'(m_req),  32'(eig | edg));
      chk("m_we",      32'(m_we),   32'(edg & dw));
      chk("m_be",      32'(m_be),   edg ? 32'(db) : (eig ? 32'hF : 32'h0));
      chk("m_addr",    m_addr,      edg ? da : (eig ? ia : 32'h0));
      chk("m_wdata",   m_wdata,     edg ? dwd : 32'h0);
      chk("if_rvalid", 32'(if_rvalid), 32'(pend_kind == 1));
      chk("d_rvalid",  32'(d_rvalid),  32'(pend_kind == 2));
      chk("if_rdata",  if_rdata, (pend_kind == 1) ? pend_data : 32'h0);
      chk("d_rdata",   d_rdata,  (pend_kind == 2) ? pend_data : 32'h0);
      if (ir && !eig) streak = (streak < SM) ? streak + 1 : SM;
      else            streak = 0;
      if (eig)      begin pend_kind = 1; pend_data = rd(ia); end
      else if (edg) begin pend_kind = 2; pend_data = dw ? 32'h0 : rd(da); end
      else          begin pend_kind = 0; pend_data = 32'h0; end
      last_ig = eig;
   endtask

   task automatic idle();
      step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   initial begin
      int first_ig;
      rst = 1'b1;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[8'h10] = 8'h13; mem[8'h11] = 8'h05; mem[8'h12] = 8'h10; mem[8'h13] = 8'h00;
      mem[8'h40] = 8'h11; mem[8'h41] = 8'h22; mem[8'h42] = 8'h33; mem[8'h43] = 8'h44;

      // Reset: outputs and grants held low even with both sides requesting.
      @(negedge clk);
      if_req = 1'b1; d_req = 1'b1; if_addr = 32'h10; d_addr = 32'h20;
      #1;
      chk("rst_if_gnt",    32'(if_gnt), 32'h0);
      chk("rst_d_gnt",     32'(d_gnt), 32'h0);
      chk("rst_m_req",     32'(m_req), 32'h0);
      chk("rst_m_addr",    m_addr, 32'h0);
      chk("rst_if_rvalid", 32'(if_rvalid), 32'h0);
      chk("rst_d_rvalid",  32'(d_rvalid), 32'h0);
      @(negedge clk);
      rst = 1'b0; if_req = 1'b0; d_req = 1'b0;

      // Single fetch.
      step(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      idle();
      chk("fetch_word", if_rdata, 32'h00100513);

      // Collision: data wins.
      step(1'b1, 32'h14, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
      idle();
      chk("coll_d_rvalid",  32'(d_rvalid), 32'h1);
      chk("coll_if_rvalid", 32'(if_rvalid), 32'h0);

      // Partial store then load back.
      step(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h40, 32'hAABBCCDD);
      step(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
      idle();
      chk("ld_after_st", d_rdata, 32'h4433CCDD);

      // Fetch starvation under continuous data traffic.
      first_ig = 0;
      for (int c = 1; c <= 20; c++) begin
         step(1'b1, 32'h18, 1'b1, 1'b0, 4'hF, 32'h24, 32'h0);
         if (last_ig && first_ig == 0) first_ig = c;
      end
      idle();
`ifdef IMEM_ARB_STARVE_GUARD_EN
      chk("starve_first_ig", 32'(first_ig), 32'd5);
`else
      chk("starve_first_ig", 32'(first_ig), 32'd0);
`endif

      // Alternating owners, back to back.
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) step(1'b1, 32'(4 * i), 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
         else            step(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'(32'h80 + 4 * i), 32'h0);
      end
      idle();

      // Reset right after a fetch grant drops its response.
      step(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid_if_rvalid", 32'(if_rvalid), 32'h0);
      chk("rst_mid_if_rdata",  if_rdata, 32'h0);
      chk("rst_mid_if_gnt",    32'(if_gnt), 32'h0);
      chk("rst_mid_m_req",     32'(m_req), 32'h0);
      @(negedge clk);
      rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
      pend_kind = 0; pend_data = 32'h0; streak = 0;
      #1;
      chk("rst_rel_if_rvalid", 32'(if_rvalid), 32'h0);
      idle();
      step(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      idle();

      // Randomized traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         step(1'($urandom_range(0, 3) != 0), 32'($urandom_range(0, 63) * 4),
              1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
              4'($urandom), 32'($urandom_range(0, 63) * 4), $urandom);
      end
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Shares the single 1-cycle-latency memory port between the pipeline's instruction fetch stage and its load/store stage. Each cycle it grants at most one requester and drives the memory port. It routes the registered read data back to the owner one cycle later with a valid pulse. An optional starvation guard keeps fetch from being locked out by back-to-back data accesses.

## Interface
Parameters:
- ADDR_W, 32, byte address width on all ports
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win (1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch requests a read this cycle
- if_addr  in  ADDR_W  fetch byte address (word-aligned)
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  if_rdata valid (one cycle after grant)
- if_rdata  out  32  fetched instruction word
- d_req  in  1  data stage requests an access
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  byte enables for stores
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  store data
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  load data valid / store acknowledged
- d_rdata  out  32  load data; 0 on store acks
- m_req, m_we  out  1  memory access strobe and write select
- m_be  out  4  memory byte enables
- m_addr  out  ADDR_W  memory address
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data, valid the cycle after m_req

## Operation
- Arbitration is combinational within the cycle. The memory always accepts, so one access can issue every cycle.
- Default priority is data over fetch: d_req wins, and if_req gets if_gnt only when d_req=0.
- The starve counter increments each cycle that if_req=1 and if_gnt=0. It clears when if_gnt=1 or if_req=0, and saturates at STARVE_MAX.
- When the starve counter equals STARVE_MAX and if_req=1, fetch wins and d_gnt=0 that cycle.
- The winning requester's fields drive the m_* outputs. When no request is granted, m_req=0 and m_we=0, with the remaining m_* outputs held at 0.
- A granted fetch always drives m_we=0 and m_be=4'hF.
- Response-owner FSM, registered each cycle:
  - IDLE → RESP_IF on fetch grant.
  - IDLE → RESP_D on data grant.
  - Any state → IDLE with no grant.
  - RESP_IF and RESP_D move directly to each other on a back-to-back grant.
- In RESP_IF: if_rvalid=1 and if_rdata=m_rdata. In RESP_D: d_rvalid=1, with d_rdata=m_rdata for a load and d_rdata=0 for a store (write-type captured at grant). Unselected rdata outputs read 0.
- Requesters must hold their request and fields until they see a grant. Address changes while ungranted are legal and take effect immediately.

## Timing
- Reset (async assert, release synchronous to clk):
  - FSM goes to IDLE, starve counter to 0, captured write-type to 0.
  - All registered outputs go to 0, so if_rvalid=d_rvalid=0.
  - Grants and m_* are driven 0 while rst=1.
- Grant-to-rvalid latency is exactly 1 cycle, and sustained throughput is 1 access per cycle.
- A reset mid-flight discards the outstanding response: no rvalid is issued for an access granted in the cycle rst asserts.
- If if_req and d_req assert on the same cycle as a starve-counter saturation, fetch wins. The counter is 0 the next cycle.
- No request is ever granted to both sides in one cycle: if_gnt & d_gnt == 0 always.

## Configuration
- IMEM_ARB_STARVE_GUARD_EN:
  - Defined: the starve counter and forced-fetch rule are present as described.
  - Undefined: strict data priority, no counter logic, and STARVE_MAX is ignored. Fetch may wait indefinitely while d_req stays high.

## Test plan
- Reset release, then if_req=1 with if_addr=0x10 and mem[0x10..0x13]=13 05 10 00 → if_gnt=1 in cycle 0; if_rvalid=1 and if_rdata=0x00100513 in cycle 1.
- if_req=1 and d_req=1 (load, addr 0x20) in the same cycle → d_gnt=1, if_gnt=0. Next cycle d_rvalid=1 with d_rdata=mem word 0x20 and if_rvalid=0.
- Store d_addr=0x40, d_be=4'b0011, d_wdata=0xAABBCCDD, then a load of 0x40 → d_rvalid ack with d_rdata=0 for the store; the load returns lower half 0xCCDD and upper bytes unchanged.
- Guard enabled, STARVE_MAX=4, d_req held high with if_req high → if_gnt=1 on the 5th cycle and d_gnt=0 that cycle. Without the macro, if_gnt stays 0 for 20 cycles.
- Alternating fetch and data grants on consecutive cycles → rvalid alternates between the sides each cycle with the correct data and no bubbles.
- Assert rst in the cycle after a fetch grant → if_rvalid stays 0 and all outputs are 0 until the first grant after release.
